// File: rtl/usb_rx_frontend_pkg.sv
// Shared types and constants for the USB receive front end.
// Contents: line-state and receiver-state enums, packet limits,
// counter widths, and the (dp, dm) -> line-state classifier.
package usb_rx_pkg;

  localparam int unsigned MAX_BITS    = 99;
  localparam int unsigned IDLE_J      = 7;
  localparam int unsigned STUFF_LIMIT = 6;
  localparam int unsigned SYNC_LEN    = 8;

  localparam int unsigned SYNC_CNT_W  = 3;
  localparam int unsigned ONES_CNT_W  = 3;
  localparam int unsigned BIT_CNT_W   = 7;
  localparam int unsigned J_CNT_W     = 3;

  typedef enum logic [1:0] {
    LS_J,
    LS_K,
    LS_SE0,
    LS_SE1
  } line_state_e;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP1,
    EOP2,
    ABORT
  } rx_state_e;

  // Full-speed line levels: J = dp high, K = dm high.
  function automatic line_state_e classify_line(input logic dp, input logic dm);
    line_state_e ls;
    case ({dp, dm})
      2'b10:   ls = LS_J;
      2'b01:   ls = LS_K;
      2'b00:   ls = LS_SE0;
      default: ls = LS_SE1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/usb_rx_frontend_if.sv
// Bus between the line sampler / packet decoder and the receive front end.
// Line side:    in_valid, dp, dm
// Decoder side: rx_bit, rx_bit_avail, rx_done, rx_err, rx_active
// slave  = the front end itself; master = whoever drives the line samples.
interface usb_rx_frontend_if;
  logic in_valid;
  logic dp;
  logic dm;
  logic rx_bit;
  logic rx_bit_avail;
  logic rx_done;
  logic rx_err;
  logic rx_active;

  modport slave (
    input  in_valid, dp, dm,
    output rx_bit, rx_bit_avail, rx_done, rx_err, rx_active
  );

  modport master (
    output in_valid, dp, dm,
    input  rx_bit, rx_bit_avail, rx_done, rx_err, rx_active
  );
endinterface

// File: rtl/usb_rx_frontend_bit_unstuffer.sv
// Bit unstuffer: tracks consecutive decoded ones and drops the stuffed zero.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bit_i, strobe_i   decoded NRZI bit and its qualifier
//   clear_i           forces the ones counter to zero
//   bit_out_o         pass-through data bit (combinational)
//   bit_out_avail_o   bit_out_o is a real data bit this cycle (combinational)
//   stuff_err_o       a one arrived where a stuffed zero was due (combinational)
module bit_unstuffer
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_i,
  input  logic strobe_i,
  input  logic clear_i,
  output logic bit_out_o,
  output logic bit_out_avail_o,
  output logic stuff_err_o
);

  logic [ONES_CNT_W-1:0] ones_cnt_q, ones_cnt_d;
  logic                  at_limit;

  // After STUFF_LIMIT ones the next bit is the stuffed one; the counter never passes it.
  always_comb begin
    at_limit        = (ones_cnt_q == ONES_CNT_W'(STUFF_LIMIT));
    bit_out_o       = bit_i;
    bit_out_avail_o = strobe_i && !at_limit;
    stuff_err_o     = strobe_i && at_limit && bit_i;
    ones_cnt_d      = ones_cnt_q;
    if (clear_i) begin
      ones_cnt_d = '0;
    end else if (strobe_i) begin
      if (at_limit || !bit_i) ones_cnt_d = '0;
      else                    ones_cnt_d = ones_cnt_q + ONES_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ones_cnt_q <= '0;
    else     ones_cnt_q <= ones_cnt_d;
  end

endmodule

// File: rtl/usb_rx_frontend.sv
// USB full-speed receive front end: SYNC detect, NRZI decode, bit unstuffing,
// EOP detect and line-protocol error flagging ahead of the packet decoder.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   usb_rx_frontend_if.slave (line samples in, decoder strobes out)
// All outputs are registered and respond one cycle after the causing sample.
module usb_rx_frontend
  import usb_rx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  usb_rx_frontend_if.slave   bus
);

  rx_state_e state_q, state_d;

  logic                  prev_j_q, prev_j_d;
  logic [SYNC_CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [J_CNT_W-1:0]    j_cnt_q, j_cnt_d;
  logic                  se0_prev_q, se0_prev_d;
  logic                  rx_bit_q, rx_bit_d;
  logic                  rx_bit_avail_q, rx_bit_avail_d;
  logic                  rx_done_q, rx_done_d;
  logic                  rx_err_q, rx_err_d;
  logic                  rx_active_q, rx_active_d;

  line_state_e ls_c;
  logic        is_j_c, is_k_c, is_jk_c, dec_bit_c;
  logic        sync_last_c, sync_ok_c, overflow_c;
  logic        us_strobe_c, us_clear_c, us_bit, us_avail, us_err;

  // Line classification, NRZI decode and SYNC pattern expectation.
  always_comb begin
    ls_c        = classify_line(bus.dp, bus.dm);
    is_j_c      = (ls_c == LS_J);
    is_k_c      = (ls_c == LS_K);
    is_jk_c     = bus.in_valid && (is_j_c || is_k_c);
    dec_bit_c   = (is_j_c == prev_j_q);
    sync_last_c = (sync_cnt_q == SYNC_CNT_W'(SYNC_LEN - 1));
    // Sample n+1 of SYNC is J when n is odd, except the final sample which repeats K.
    sync_ok_c   = (sync_last_c || !sync_cnt_q[0]) ? is_k_c : is_j_c;
    overflow_c  = us_avail && (bit_cnt_q == BIT_CNT_W'(MAX_BITS));
    // SYNC decodes to 0000_0001, so strobing through SYNC leaves ones_cnt at 1 on entry to DATA.
    us_strobe_c = is_jk_c && ((state_q == SYNC) || (state_q == DATA));
    us_clear_c  = (state_q != SYNC) && (state_q != DATA);
  end

  bit_unstuffer u_unstuffer (
    .clk             (clk),
    .rst             (rst),
    .bit_i           (dec_bit_c),
    .strobe_i        (us_strobe_c),
    .clear_i         (us_clear_c),
    .bit_out_o       (us_bit),
    .bit_out_avail_o (us_avail),
    .stuff_err_o     (us_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.in_valid) begin
      case (state_q)
        IDLE:  if (is_k_c) state_d = SYNC;
        SYNC: begin
          if (!sync_ok_c)       state_d = ABORT;
          else if (sync_last_c) state_d = DATA;
        end
        DATA: begin
          if (ls_c == LS_SE0)                state_d = EOP1;
          else if (ls_c == LS_SE1)           state_d = ABORT;
          else if (us_err || overflow_c)     state_d = ABORT;
        end
        EOP1:  state_d = (ls_c == LS_SE0) ? EOP2 : ABORT;
        EOP2:  state_d = is_j_c ? IDLE : ABORT;
        ABORT: if (is_j_c && (se0_prev_q || j_cnt_q == J_CNT_W'(IDLE_J - 1))) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    prev_j_d       = prev_j_q;
    sync_cnt_d     = sync_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    j_cnt_d        = j_cnt_q;
    se0_prev_d     = se0_prev_q;
    rx_bit_d       = 1'b0;
    rx_bit_avail_d = 1'b0;
    rx_done_d      = 1'b0;
    rx_err_d       = 1'b0;
    rx_active_d    = (state_d == DATA) || (state_d == EOP1) || (state_d == EOP2);

    if (bus.in_valid) begin
      se0_prev_d = (ls_c == LS_SE0);
      if (is_jk_c) prev_j_d = is_j_c;
      case (state_q)
        IDLE: sync_cnt_d = is_k_c ? SYNC_CNT_W'(1) : '0;
        SYNC: begin
          sync_cnt_d = sync_cnt_q + SYNC_CNT_W'(1);
          bit_cnt_d  = '0;
        end
        DATA: begin
          if (ls_c == LS_SE1) begin
            rx_err_d = 1'b1;
          end else if (is_jk_c) begin
            if (us_err || overflow_c) begin
              rx_err_d = 1'b1;
            end else if (us_avail) begin
              rx_bit_d       = us_bit;
              rx_bit_avail_d = 1'b1;
              bit_cnt_d      = bit_cnt_q + BIT_CNT_W'(1);
            end
          end
        end
        EOP1:  rx_err_d  = (ls_c != LS_SE0);
        EOP2: begin
          rx_done_d = is_j_c;
          rx_err_d  = !is_j_c;
        end
        ABORT: j_cnt_d = is_j_c ? j_cnt_q + J_CNT_W'(1) : '0;
        default: ;
      endcase
    end
    if (state_d != ABORT) j_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_j_q       <= 1'b1;
      sync_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      j_cnt_q        <= '0;
      se0_prev_q     <= 1'b0;
      rx_bit_q       <= 1'b0;
      rx_bit_avail_q <= 1'b0;
      rx_done_q      <= 1'b0;
      rx_err_q       <= 1'b0;
      rx_active_q    <= 1'b0;
    end else begin
      prev_j_q       <= prev_j_d;
      sync_cnt_q     <= sync_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      j_cnt_q        <= j_cnt_d;
      se0_prev_q     <= se0_prev_d;
      rx_bit_q       <= rx_bit_d;
      rx_bit_avail_q <= rx_bit_avail_d;
      rx_done_q      <= rx_done_d;
      rx_err_q       <= rx_err_d;
      rx_active_q    <= rx_active_d;
    end
  end

  assign bus.rx_bit       = rx_bit_q;
  assign bus.rx_bit_avail = rx_bit_avail_q;
  assign bus.rx_done      = rx_done_q;
  assign bus.rx_err       = rx_err_q;
  assign bus.rx_active    = rx_active_q;

endmodule

// File: tb/tb_usb_rx_frontend.sv
// Testbench for usb_rx_frontend. Packets are built from payload bits,
// stuffed and NRZI-encoded here; the expected decoder events are derived
// from the payload and queued, and a monitor pops them as the DUT reports.
module tb_usb_rx_frontend;
  import usb_rx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_rx_frontend_if bus();

  usb_rx_frontend dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_BIT, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct packed {
    ev_kind_e kind;
    logic     b;
  } ev_t;

  ev_t  exp_q[$];
  bit   pkt[$];
  bit   saved[$];
  int   total = 0;
  int   bad   = 0;
  int   gap   = 0;
  logic lvl_j = 1'b1;
  int   ones  = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic b);
    ev_t e;
    e.kind = k;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  // One valid sample, then `gap` cycles with in_valid low and junk on the line.
  task automatic drive(input logic dp, input logic dm);
    bus.in_valid = 1'b1;
    bus.dp       = dp;
    bus.dm       = dm;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dp       = 1'($urandom_range(0, 1));
    bus.dm       = 1'($urandom_range(0, 1));
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_level(input logic j);
    if (j) drive(1'b1, 1'b0);
    else   drive(1'b0, 1'b1);
    lvl_j = j;
  endtask

  task automatic send_se0();
    drive(1'b0, 1'b0);
  endtask

  task automatic send_sync();
    logic [7:0] pat;
    pat = 8'b0101_0100;  // 1 = J, first sample is MSB: K J K J K J K K
    for (int i = 7; i >= 0; i--) send_level(pat[i]);
    ones = 1;
  endtask

  // NRZI: a 1 keeps the level, a 0 toggles; after six ones a 0 is inserted.
  task automatic send_bit(input bit b, input bit stuff);
    send_level(b ? lvl_j : !lvl_j);
    ones = b ? ones + 1 : 0;
    if (stuff && ones == STUFF_LIMIT) begin
      send_level(!lvl_j);
      ones = 0;
    end
  endtask

  task automatic recover();
    repeat (IDLE_J) send_level(1'b1);
  endtask

  task automatic send_good_packet();
    foreach (pkt[i]) push(EV_BIT, pkt[i]);
    push(EV_DONE, 1'b0);
    send_sync();
    foreach (pkt[i]) send_bit(pkt[i], 1'b1);
    send_se0();
    send_se0();
    send_level(1'b1);
  endtask

  task automatic rand_pkt(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back($urandom_range(0, 3) != 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_bit"},       int'(bus.rx_bit),       0);
    check({tag, "_rx_bit_avail"}, int'(bus.rx_bit_avail), 0);
    check({tag, "_rx_done"},      int'(bus.rx_done),      0);
    check({tag, "_rx_err"},       int'(bus.rx_err),       0);
    check({tag, "_rx_active"},    int'(bus.rx_active),    0);
  endtask

  // Monitor: every reported event must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    ev_t act_ev;
    ev_t exp_ev;
    if (bus.rx_bit_avail || bus.rx_done || bus.rx_err) begin
      check("exclusive_strobes",
            $countones({bus.rx_bit_avail, bus.rx_done, bus.rx_err}), 1);
      act_ev.kind = bus.rx_bit_avail ? EV_BIT : (bus.rx_done ? EV_DONE : EV_ERR);
      act_ev.b    = bus.rx_bit_avail ? bus.rx_bit : 1'b0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: actual kind=%0d required none", int'(act_ev.kind));
      end else begin
        exp_ev = exp_q.pop_front();
        check("event_kind", int'(act_ev.kind), int'(exp_ev.kind));
        if (exp_ev.kind == EV_BIT) check("rx_bit", int'(act_ev.b), int'(exp_ev.b));
        check("rx_active", int'(bus.rx_active), (exp_ev.kind == EV_BIT) ? 1 : 0);
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.dp       = 1'b1;
    bus.dm       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Good token: PID 1110_0001 then 16 more bits.
    pkt = '{1, 1, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 16; i++) pkt.push_back(1'($urandom_range(0, 1)));
    saved = pkt;
    send_good_packet();
    repeat (2) send_level(1'b1);

    // Eight ones: one stuffed zero must be dropped.
    pkt = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_good_packet();

    // Stuff error: a one where the stuffed zero is due.
    push(EV_BIT, 1'b0);
    repeat (STUFF_LIMIT) push(EV_BIT, 1'b1);
    push(EV_ERR, 1'b0);
    send_sync();
    send_bit(1'b0, 1'b0);
    repeat (STUFF_LIMIT + 1) send_bit(1'b1, 1'b0);
    recover();

    // SYNC noise: aborts silently; the following packet is still received.
    send_level(1'b0);
    send_level(1'b1);
    send_level(1'b1);
    recover();
    send_level(1'b0);
    send_se0();
    recover();
    rand_pkt(12);
    send_good_packet();

    // EOP with a single SE0 followed by J.
    rand_pkt(10);
    foreach (pkt[i]) push(EV_BIT, pkt[i]);
    push(EV_ERR, 1'b0);
    send_sync();
    foreach (pkt[i]) send_bit(pkt[i], 1'b1);
    send_se0();
    send_level(1'b1);
    recover();

    // EOP with three SE0s.
    rand_pkt(9);
    foreach (pkt[i]) push(EV_BIT, pkt[i]);
    push(EV_ERR, 1'b0);
    send_sync();
    foreach (pkt[i]) send_bit(pkt[i], 1'b1);
    repeat (3) send_se0();
    recover();

    // Overflow: 100th bit is an error and is not emitted.
    rand_pkt(MAX_BITS + 1);
    for (int i = 0; i < MAX_BITS; i++) push(EV_BIT, pkt[i]);
    push(EV_ERR, 1'b0);
    send_sync();
    foreach (pkt[i]) send_bit(pkt[i], 1'b1);
    recover();

    // Maximum-length packet completes normally.
    rand_pkt(MAX_BITS);
    send_good_packet();

    // Same good token with 3 idle cycles between samples.
    gap = 3;
    pkt = saved;
    send_good_packet();
    gap = 0;

    // Randomized packets, gaps and idle time.
    for (int n = 0; n < 20; n++) begin
      gap = $urandom_range(0, 2);
      rand_pkt($urandom_range(1, MAX_BITS));
      send_good_packet();
      repeat ($urandom_range(0, 3)) send_level(1'b1);
    end
    gap = 0;

    // Reset in the middle of DATA: no done or err for the lost packet.
    rand_pkt(5);
    foreach (pkt[i]) push(EV_BIT, pkt[i]);
    send_sync();
    foreach (pkt[i]) send_bit(pkt[i], 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    rst   = 1'b0;
    lvl_j = 1'b1;
    rand_pkt(20);
    send_good_packet();

    repeat (20) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
